// File: rtl/decoder_pipe.sv
// decoder_pipe: registered instruction decode stage with a 1-entry skid buffer.
// Ports: clk, RST (async active-low), in_valid/in_ready/INSTR_IN (fetch side),
//   flush, out_valid/out_ready (execute side), decoded bundle: opcode, src,
//   src2, dst, imm, jump, ctrl_PC, write_BR, read_BR, write_ALU, ld, illegal,
//   hazard. Optional macro DECODER_HAZARD_EN enables RAW hazard tracking.
module decoder_pipe #(
    parameter int IW  = 32,
    parameter int RW  = 6,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           RST,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [IW-1:0]  INSTR_IN,
    input  logic           flush,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OPW-1:0] opcode,
    output logic [RW-1:0]  src,
    output logic [RW-1:0]  src2,
    output logic [RW-1:0]  dst,
    output logic [IW-2:0]  imm,
    output logic [IW-1:0]  jump,
    output logic [1:0]     ctrl_PC,
    output logic           write_BR,
    output logic           read_BR,
    output logic           write_ALU,
    output logic           ld,
    output logic           illegal,
    output logic           hazard
);

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    typedef struct packed {
        logic [OPW-1:0] opcode;
        logic [RW-1:0]  src;
        logic [RW-1:0]  src2;
        logic [RW-1:0]  dst;
        logic [IW-2:0]  imm;
        logic [IW-1:0]  jump;
        logic [1:0]     ctrl_pc;
        logic           write_br;
        logic           read_br;
        logic           write_alu;
        logic           ld;
        logic           illegal;
    } bundle_t;

    function automatic bundle_t decode(input logic [IW-1:0] w);
        bundle_t    b;
        logic [6:0] cls;
        b   = '0;
        cls = w[IW-1:IW-7];
        unique case (1'b1)
            cls[6]: begin
                b.opcode  = OPW'(4'd1);
                b.ctrl_pc = 2'd1;
                b.jump    = {1'b0, w[IW-2:0]};
                b.imm     = w[IW-2:0];
            end
            cls[6:5] == 2'b01: begin
                b.opcode = OPW'(4'd2);
                b.ld     = 1'b1;
                b.dst    = w[3*RW-1:2*RW];
                b.imm[IW-3-RW:0] = {w[IW-3:3*RW], w[2*RW-1:0]};
            end
            cls[6:2] == 5'b00010: begin
                b.opcode   = OPW'(4'd3);
                b.write_br = 1'b1;
                b.src      = w[RW-1:0];
                b.src2     = w[2*RW-1:RW];
            end
            cls[6:2] == 5'b00011: begin
                b.opcode  = OPW'(4'd4);
                b.read_br = 1'b1;
                b.src2    = w[2*RW-1:RW];
                b.dst     = w[3*RW-1:2*RW];
            end
            cls[6:3] == 4'b0010,
            cls[6:3] == 4'b0011: begin
                b.opcode = cls[3] ? OPW'(4'd6) : OPW'(4'd5);
                b.src    = w[RW-1:0];
                b.src2   = w[2*RW-1:RW];
                b.imm[IW-5-2*RW:0] = w[IW-5:2*RW];
            end
            default: begin
                // ALU / NOP space: reserved bits nonzero poisons the word
                if (|w[IW-8:3*RW]) begin
                    b.illegal = 1'b1;
                end else if (cls[2:0] != 3'd0) begin
                    b.opcode    = OPW'({1'b0, cls[2:0]} + 4'd6);
                    b.write_alu = 1'b1;
                    b.src       = w[RW-1:0];
                    b.src2      = w[2*RW-1:RW];
                    b.dst       = w[3*RW-1:2*RW];
                end
            end
        endcase
        return b;
    endfunction

    state_t  state_q, state_d;
    logic    in_ready_q, in_ready_d;
    bundle_t out_q, out_d;
    bundle_t skid_q, skid_d;
    bundle_t dec;
    logic    accept, consume;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        dec     = decode(INSTR_IN);
        accept  = in_valid & in_ready_q;
        consume = (state_q != S_EMPTY) & out_ready;
        if (flush) begin
            state_d = S_EMPTY;
            out_d   = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        out_d   = dec;
                        state_d = S_ONE;
                    end
                end
                S_ONE: begin
                    if (accept && consume) begin
                        out_d = dec;
                    end else if (accept) begin
                        skid_d  = dec;
                        state_d = S_TWO;
                    end else if (consume) begin
                        out_d   = '0;
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (consume) begin
                        out_d   = skid_q;
                        skid_d  = '0;
                        state_d = S_ONE;
                    end
                end
                default: begin
                    out_d   = '0;
                    skid_d  = '0;
                    state_d = S_EMPTY;
                end
            endcase
        end
        // registered ready: no combinational path from out_ready
        in_ready_d = (state_d != S_TWO);
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q    <= S_EMPTY;
            in_ready_q <= 1'b1;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != S_EMPTY);
    assign opcode    = out_q.opcode;
    assign src       = out_q.src;
    assign src2      = out_q.src2;
    assign dst       = out_q.dst;
    assign imm       = out_q.imm;
    assign jump      = out_q.jump;
    assign ctrl_PC   = out_q.ctrl_pc;
    assign write_BR  = out_q.write_br;
    assign read_BR   = out_q.read_br;
    assign write_ALU = out_q.write_alu;
    assign ld        = out_q.ld;
    assign illegal   = out_q.illegal;

`ifdef DECODER_HAZARD_EN
    logic [RW-1:0] hist_dst_q, hist_dst_d;
    logic          hist_wr_q, hist_wr_d;
    logic          rd_s, rd_s2;

    always_comb begin
        hist_dst_d = hist_dst_q;
        hist_wr_d  = hist_wr_q;
        if (flush) begin
            hist_dst_d = '0;
            hist_wr_d  = 1'b0;
        end else if (consume) begin
            hist_dst_d = out_q.dst;
            // illegal bundles carry NOP controls, so they never arm history
            hist_wr_d  = out_q.ld | out_q.read_br | out_q.write_alu;
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            hist_dst_q <= '0;
            hist_wr_q  <= 1'b0;
        end else begin
            hist_dst_q <= hist_dst_d;
            hist_wr_q  <= hist_wr_d;
        end
    end

    always_comb begin
        rd_s  = out_q.write_alu | out_q.write_br
              | (out_q.opcode == OPW'(4'd5))
              | (out_q.opcode == OPW'(4'd6));
        rd_s2 = rd_s | out_q.read_br;
    end

    assign hazard = out_valid & hist_wr_q
                  & ((rd_s & (out_q.src == hist_dst_q))
                   | (rd_s2 & (out_q.src2 == hist_dst_q)));
`else
    assign hazard = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_pipe.sv
// tb_decoder_pipe: directed and randomized checks of decoder_pipe against
// a queue-based reference model decoding words from the ISA rules.
module tb_decoder_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] instr;
    logic [3:0]  opcode;
    logic [5:0]  src, src2, dst;
    logic [30:0] imm;
    logic [31:0] jump;
    logic [1:0]  ctrl_pc;
    logic        write_br, read_br, write_alu, ld, illegal, hazard;

`ifdef DECODER_HAZARD_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    decoder_pipe #(.IW(32), .RW(6), .OPW(4)) dut (
        .clk(clk), .RST(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .INSTR_IN(instr),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .src(src), .src2(src2), .dst(dst),
        .imm(imm), .jump(jump), .ctrl_PC(ctrl_pc),
        .write_BR(write_br), .read_BR(read_br),
        .write_ALU(write_alu), .ld(ld),
        .illegal(illegal), .hazard(hazard)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [5:0]  src, src2, dst;
        logic [30:0] imm;
        logic [31:0] jump;
        logic [1:0]  ctrl;
        logic        wbr, rbr, walu, ld, ill;
    } exp_t;

    int          ntests = 0;
    int          nfail  = 0;
    logic [31:0] q[$];
    logic [5:0]  hist_dst = '0;
    bit          hist_wr  = 1'b0;

    function automatic exp_t mdec(input logic [31:0] w);
        exp_t e;
        int   cls;
        e   = '0;
        cls = int'(w[31:25]);
        if (cls >= 64) begin
            e.op = 1; e.ctrl = 1;
            e.jump = {1'b0, w[30:0]}; e.imm = w[30:0];
        end else if (cls >= 32) begin
            e.op = 2; e.ld = 1; e.dst = w[17:12];
            e.imm = 31'({w[29:18], w[11:0]});
        end else if (cls >= 16) begin
            e.op = (cls < 24) ? 4'd5 : 4'd6;
            e.src = w[5:0]; e.src2 = w[11:6];
            e.imm = 31'(w[27:12]);
        end else if (cls >= 12) begin
            e.op = 4; e.rbr = 1; e.src2 = w[11:6]; e.dst = w[17:12];
        end else if (cls >= 8) begin
            e.op = 3; e.wbr = 1; e.src = w[5:0]; e.src2 = w[11:6];
        end else if (w[24:18] != 0) begin
            e.ill = 1;
        end else if (cls > 0) begin
            e.op = 4'(6 + cls); e.walu = 1;
            e.src = w[5:0]; e.src2 = w[11:6]; e.dst = w[17:12];
        end
        return e;
    endfunction

    function automatic bit reads1(input exp_t e);
        return e.op == 3 || e.op == 5 || e.op == 6 || e.op >= 7;
    endfunction

    function automatic bit writes(input exp_t e);
        return e.op == 2 || e.op == 4 || e.op >= 7;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        exp_t e;
        bit   hz;
        e  = (q.size() > 0) ? mdec(q[0]) : '0;
        hz = HZ && q.size() > 0 && hist_wr &&
             ((reads1(e) && e.src == hist_dst) ||
              ((reads1(e) || e.op == 4) && e.src2 == hist_dst));
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready",  64'(in_ready),  64'(q.size() < 2));
        chk("opcode",  64'(opcode),  64'(e.op));
        chk("src",     64'(src),     64'(e.src));
        chk("src2",    64'(src2),    64'(e.src2));
        chk("dst",     64'(dst),     64'(e.dst));
        chk("imm",     64'(imm),     64'(e.imm));
        chk("jump",    64'(jump),    64'(e.jump));
        chk("ctrl_pc", 64'(ctrl_pc), 64'(e.ctrl));
        chk("strobes", 64'({write_br, read_br, write_alu, ld}),
            64'({e.wbr, e.rbr, e.walu, e.ld}));
        chk("illegal", 64'(illegal), 64'(e.ill));
        chk("hazard",  64'(hazard),  64'(hz));
    endtask

    task automatic step(input logic v, input logic [31:0] w,
                        input logic rdy, input logic fl);
        bit   acc, con;
        exp_t e;
        check_all();
        in_valid = v; instr = w; out_ready = rdy; flush = fl;
        acc = v && q.size() < 2;
        con = q.size() > 0 && rdy;
        @(posedge clk);
        if (fl) begin
            q.delete(); hist_wr = 0; hist_dst = '0;
        end else begin
            if (con) begin
                e = mdec(q[0]);
                hist_wr = writes(e); hist_dst = e.dst;
                void'(q.pop_front());
            end
            if (acc) q.push_back(w);
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 1) == 1)
            w[31:25] = 7'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1) w[24:18] = '0;
        w[5:0]   = 6'($urandom_range(0, 3));
        w[11:6]  = 6'($urandom_range(0, 3));
        w[17:12] = 6'($urandom_range(0, 3));
        return w;
    endfunction

    localparam logic [31:0] W_ADD = 32'h0201_5083;
    localparam logic [31:0] W_JMP = 32'h8000_0040;
    localparam logic [31:0] W_WR  = 32'h1000_0000;
    localparam logic [31:0] W_RD  = 32'h1800_0000;
    localparam logic [31:0] W_BEQ = 32'h2000_0000;
    localparam logic [31:0] W_ILL = 32'h0204_0000;
    localparam logic [31:0] W_LD4 = 32'h4000_4000;
    localparam logic [31:0] W_AD4 = 32'h0200_0004;

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; instr = W_ADD;
        out_ready = 1'b1; flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_ready", 64'(in_ready), 64'(1));
        chk("rst_op", 64'(opcode), 64'(0));
        chk("rst_dst", 64'(dst), 64'(0));
        rst_n = 1'b1;

        step(1, W_ADD, 1, 0);
        chk("add_op", 64'(opcode), 64'(7));
        chk("add_alu", 64'(write_alu), 64'(1));
        chk("add_dst", 64'(dst), 64'(21));
        chk("add_src2", 64'(src2), 64'(2));
        chk("add_src", 64'(src), 64'(3));
        chk("add_ill", 64'(illegal), 64'(0));

        step(1, W_JMP, 1, 0);
        chk("jmp_op", 64'(opcode), 64'(1));
        chk("jmp_pc", 64'(ctrl_pc), 64'(1));
        chk("jmp_tgt", 64'(jump), 64'(32'h40));
        chk("jmp_imm", 64'(imm), 64'(31'h40));

        step(0, 0, 1, 0);
        step(1, W_WR, 0, 0);
        step(1, W_RD, 0, 0);
        chk("bp_ready", 64'(in_ready), 64'(0));
        step(1, W_BEQ, 0, 0);
        chk("bp_first", 64'(opcode), 64'(3));
        step(0, 0, 1, 0);
        chk("bp_second", 64'(opcode), 64'(4));
        step(0, 0, 1, 0);
        chk("bp_drain", 64'(out_valid), 64'(0));

        step(1, W_WR, 0, 0);
        step(1, W_RD, 0, 0);
        step(1, W_BEQ, 0, 1);
        chk("fl_valid", 64'(out_valid), 64'(0));
        chk("fl_ready", 64'(in_ready), 64'(1));
        chk("fl_op", 64'(opcode), 64'(0));

        step(1, W_ILL, 1, 0);
        chk("ill_flag", 64'(illegal), 64'(1));
        chk("ill_op", 64'(opcode), 64'(0));
        chk("ill_alu", 64'(write_alu), 64'(0));
        step(1, W_LD4, 1, 0);
        step(1, W_AD4, 1, 0);
        chk("hz_add", 64'(hazard), 64'(HZ));
        step(0, 0, 1, 0);

        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 9) < 7), rnd_word(),
                 1'($urandom_range(0, 9) < 6),
                 1'($urandom_range(0, 29) == 0));

        step(1, W_WR, 0, 0);
        step(1, W_RD, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_valid", 64'(out_valid), 64'(0));
        chk("mrst_ready", 64'(in_ready), 64'(1));
        chk("mrst_op", 64'(opcode), 64'(0));
        q.delete(); hist_wr = 0; hist_dst = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++)
            step(1'($urandom_range(0, 1)), rnd_word(),
                 1'($urandom_range(0, 1)), 1'b0);
        check_all();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
